// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional second (skid) entry that keeps ready_o fully registered.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W   = 8,
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CLR_DATA = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    // Low in reset, then tracks "skid entry empty"; with SKID=0 it only masks reset.
    logic              rdy_q, rdy_d;
    logic              in_xfer, out_xfer;

    assign ready_o  = (SKID != 0) ? rdy_q : (rdy_q & (~main_valid_q | ready_i));
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = main_valid_q & ready_i;

    // Next-state for both entries; flush beats any transfer.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            if (CLR_DATA != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (skid_valid_q) begin
            // ready_o is low here, so only the skid-to-main move can happen.
            if (out_xfer) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end
        end else if (in_xfer && main_valid_q && !out_xfer && (SKID != 0)) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = ctrl_i;
            skid_data_d  = data_i;
        end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = ctrl_i;
            main_data_d  = data_i;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end
        rdy_d = ~skid_valid_d;
    end

    // Entry and ready registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            rdy_q        <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            rdy_q        <= rdy_d;
        end
    end

    assign valid_o = main_valid_q;
    // Bubble is a NOP downstream without extra gating.
    assign ctrl_o  = main_valid_q ? main_ctrl_q : '0;
    assign data_o  = main_data_q;
    assign count_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    a_no_in_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(skid_valid_q && in_xfer));
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(ctrl_o) && $stable(data_o)));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (count_o <= 2'd2) && ((SKID != 0) || (count_o <= 2'd1)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: two SKID=1 stages (CLR_DATA=0/1) share a vector table,
// a SKID=0 stage is exercised by a short hand-written sequence.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 16;

    logic clk, rst_n;
    logic flush, valid, rdy_in;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;

    logic a_ready, a_valid, b_ready, b_valid;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [DW-1:0] a_data, b_data;
    logic [1:0] a_cnt, b_cnt;

    logic c_flush, c_valid_i, c_rdy_in, c_ready, c_valid;
    logic [CW-1:0] c_ctrl_i, c_ctrl;
    logic [DW-1:0] c_data_i, c_data;
    logic [1:0] c_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(a_ready),
        .ctrl_i(ctrl), .data_i(data), .valid_o(a_valid), .ready_i(rdy_in), .ctrl_o(a_ctrl),
        .data_o(a_data), .count_o(a_cnt));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(b_ready),
        .ctrl_i(ctrl), .data_i(data), .valid_o(b_valid), .ready_i(rdy_in), .ctrl_o(b_ctrl),
        .data_o(b_data), .count_o(b_cnt));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .valid_i(c_valid_i), .ready_o(c_ready),
        .ctrl_i(c_ctrl_i), .data_i(c_data_i), .valid_o(c_valid), .ready_i(c_rdy_in),
        .ctrl_o(c_ctrl), .data_o(c_data), .count_o(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          r;
        logic          e_v;
        logic [CW-1:0] e_c;
        logic [DW-1:0] e_d;   // CLR_DATA=0 stage
        logic [DW-1:0] e_db;  // CLR_DATA=1 stage
        logic [1:0]    e_n;
        logic          e_r;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic fl, logic v, logic [CW-1:0] c, logic [DW-1:0] d,
                                logic r, logic e_v, logic [CW-1:0] e_c, logic [DW-1:0] e_d,
                                logic [DW-1:0] e_db, logic [1:0] e_n, logic e_r);
        vec_t t;
        t.fl = fl; t.v = v; t.c = c; t.d = d; t.r = r;
        t.e_v = e_v; t.e_c = e_c; t.e_d = e_d; t.e_db = e_db; t.e_n = e_n; t.e_r = e_r;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //             fl v  ctrl   data     r  ev ectrl  edata    edataB   n  rdy
        vecs[0]  = mk(0, 1, 8'h01, 16'h10, 1, 1, 8'h01, 16'h10, 16'h10, 1, 1);
        vecs[1]  = mk(0, 1, 8'h02, 16'h11, 1, 1, 8'h02, 16'h11, 16'h11, 1, 1);
        vecs[2]  = mk(0, 1, 8'h03, 16'h12, 1, 1, 8'h03, 16'h12, 16'h12, 1, 1);
        vecs[3]  = mk(0, 0, 8'h00, 16'h00, 1, 0, 8'h00, 16'h12, 16'h12, 0, 1);
        vecs[4]  = mk(0, 1, 8'h0A, 16'h0A, 0, 1, 8'h0A, 16'h0A, 16'h0A, 1, 1);
        vecs[5]  = mk(0, 1, 8'h0B, 16'h0B, 0, 1, 8'h0A, 16'h0A, 16'h0A, 2, 0);
        vecs[6]  = mk(0, 1, 8'h0E, 16'h0E, 0, 1, 8'h0A, 16'h0A, 16'h0A, 2, 0);
        vecs[7]  = mk(0, 0, 8'h00, 16'h00, 1, 1, 8'h0B, 16'h0B, 16'h0B, 1, 1);
        vecs[8]  = mk(0, 0, 8'h00, 16'h00, 1, 0, 8'h00, 16'h0B, 16'h0B, 0, 1);
        vecs[9]  = mk(0, 1, 8'hFF, 16'h5A, 0, 1, 8'hFF, 16'h5A, 16'h5A, 1, 1);
        vecs[10] = mk(0, 1, 8'hFF, 16'h5B, 0, 1, 8'hFF, 16'h5A, 16'h5A, 2, 0);
        vecs[11] = mk(1, 1, 8'hFF, 16'h0C, 0, 0, 8'h00, 16'h5A, 16'h00, 0, 1);
        vecs[12] = mk(0, 0, 8'h00, 16'h00, 1, 0, 8'h00, 16'h5A, 16'h00, 0, 1);
        vecs[13] = mk(0, 1, 8'h11, 16'h21, 0, 1, 8'h11, 16'h21, 16'h21, 1, 1);
        vecs[14] = mk(0, 1, 8'h12, 16'h22, 1, 1, 8'h12, 16'h22, 16'h22, 1, 1);
        vecs[15] = mk(0, 1, 8'h13, 16'h23, 0, 1, 8'h12, 16'h22, 16'h22, 2, 0);
        vecs[16] = mk(0, 1, 8'h14, 16'h24, 1, 1, 8'h13, 16'h23, 16'h23, 1, 1);
        vecs[17] = mk(0, 0, 8'h00, 16'h00, 1, 0, 8'h00, 16'h23, 16'h23, 0, 1);

        flush = 0; valid = 0; rdy_in = 0; ctrl = '0; data = '0;
        c_flush = 0; c_valid_i = 0; c_rdy_in = 0; c_ctrl_i = '0; c_data_i = '0;
        rst_n = 0;

        // Reset state
        #3;
        chk("rst_ready", {31'd0, a_ready}, 0);
        chk("rst_valid", {31'd0, a_valid}, 0);
        chk("rst_ctrl", {24'd0, a_ctrl}, 0);
        chk("rst_data", {16'd0, a_data}, 0);
        chk("rst_count", {30'd0, a_cnt}, 0);
        chk("rst_ready_c", {31'd0, c_ready}, 0);
        #9 rst_n = 1;
        @(posedge clk); #1;
        chk("rel_ready", {31'd0, a_ready}, 1);
        chk("rel_count", {30'd0, a_cnt}, 0);
        chk("rel_ready_c", {31'd0, c_ready}, 1);

        for (int i = 0; i < 18; i++) begin
            flush = vecs[i].fl; valid = vecs[i].v; ctrl = vecs[i].c;
            data = vecs[i].d; rdy_in = vecs[i].r;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'd0, a_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d_ctrl", i), {24'd0, a_ctrl}, {24'd0, vecs[i].e_c});
            chk($sformatf("v%0d_data", i), {16'd0, a_data}, {16'd0, vecs[i].e_d});
            chk($sformatf("v%0d_count", i), {30'd0, a_cnt}, {30'd0, vecs[i].e_n});
            chk($sformatf("v%0d_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].e_r});
            chk($sformatf("v%0d_valid_b", i), {31'd0, b_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d_ctrl_b", i), {24'd0, b_ctrl}, {24'd0, vecs[i].e_c});
            chk($sformatf("v%0d_data_b", i), {16'd0, b_data}, {16'd0, vecs[i].e_db});
            chk($sformatf("v%0d_count_b", i), {30'd0, b_cnt}, {30'd0, vecs[i].e_n});
        end
        flush = 0; valid = 0; rdy_in = 0;

        // SKID=0: combinational ready and replace-per-edge streaming
        c_valid_i = 1; c_ctrl_i = 8'h01; c_data_i = 16'h31; c_rdy_in = 0;
        @(posedge clk); #1;
        chk("c_load_valid", {31'd0, c_valid}, 1);
        chk("c_load_data", {16'd0, c_data}, 16'h31);
        chk("c_load_count", {30'd0, c_cnt}, 1);
        chk("c_stall_ready", {31'd0, c_ready}, 0);
        c_rdy_in = 1; #1;
        chk("c_comb_ready", {31'd0, c_ready}, 1);
        c_ctrl_i = 8'h02; c_data_i = 16'h32;
        @(posedge clk); #1;
        chk("c_repl1_data", {16'd0, c_data}, 16'h32);
        chk("c_repl1_ctrl", {24'd0, c_ctrl}, 8'h02);
        chk("c_repl1_count", {30'd0, c_cnt}, 1);
        c_ctrl_i = 8'h03; c_data_i = 16'h33;
        @(posedge clk); #1;
        chk("c_repl2_data", {16'd0, c_data}, 16'h33);
        c_valid_i = 0;
        @(posedge clk); #1;
        chk("c_drain_valid", {31'd0, c_valid}, 0);
        chk("c_drain_ctrl", {24'd0, c_ctrl}, 0);
        chk("c_drain_count", {30'd0, c_cnt}, 0);

        // Asynchronous reset mid-operation
        valid = 1; ctrl = 8'h77; data = 16'h99; rdy_in = 0;
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, a_valid}, 1);
        valid = 0;
        #2 rst_n = 0; #1;
        chk("mid_rst_valid", {31'd0, a_valid}, 0);
        chk("mid_rst_ctrl", {24'd0, a_ctrl}, 0);
        chk("mid_rst_data", {16'd0, a_data}, 0);
        chk("mid_rst_count", {30'd0, a_cnt}, 0);
        chk("mid_rst_ready", {31'd0, a_ready}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
